// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU and PC-select codes,
// exception vector and the ID/EX pipeline register layout.
package core_defs;

  localparam int          NREGS      = 32;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0040;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101
  } aluop_t;

  typedef enum logic [1:0] {
    PC_BRANCH = 2'b00,
    PC_JR     = 2'b01,
    PC_JUMP   = 2'b10,
    PC_EXC    = 2'b11
  } selpc_t;

  typedef struct packed {
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imedext;
    aluop_t      aluop;
    logic        selalusrc;
    logic [4:0]  regdest;
    logic        writereg;
    logic        memread;
    logic        memwrite;
  } idex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file with write-through bypass; r0 is hardwired to zero.
module register_file
  import core_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [NREGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    if (a == 5'd0)                rd_port = '0;
    else if (we_i && waddr_i == a) rd_port = wdata_i;
    else                           rd_port = regs_q[a];
  endfunction

  assign rdata_a_o = rd_port(raddr_a_i);
  assign rdata_b_o = rd_port(raddr_b_i);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched word, reads/bypasses registers, resolves
// branches/jumps combinationally and loads the ID/EX register one cycle later.
module decode_stage
  import core_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_instruc,
  input  logic [31:0] if_id_nextpc,
  input  logic        is_id_stall,
  output logic        id_if_selpcsource,
  output logic [1:0]  id_if_selpctype,
  output logic [31:0] id_if_pcimd2ext,
  output logic [31:0] id_if_rega,
  output logic [31:0] id_if_pcindex,
  input  logic        wb_id_writereg,
  input  logic [4:0]  wb_id_regdest,
  input  logic [31:0] wb_id_data,
  output logic [31:0] id_ex_rega,
  output logic [31:0] id_ex_regb,
  output logic [31:0] id_ex_imedext,
  output logic [2:0]  id_ex_aluop,
  output logic        id_ex_selalusrc,
  output logic [4:0]  id_ex_regdest,
  output logic        id_ex_writereg,
  output logic        id_ex_memread,
  output logic        id_ex_memwrite
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, imm_ext;

  assign op    = if_id_instruc[31:26];
  assign rs    = if_id_instruc[25:21];
  assign rt    = if_id_instruc[20:16];
  assign rd    = if_id_instruc[15:11];
  assign shamt = if_id_instruc[10:6];
  assign funct = if_id_instruc[5:0];
  assign imm_ext = sext16(if_id_instruc[15:0]);

  register_file u_regfile (
    .clock     (clock),
    .reset     (reset),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .we_i      (wb_id_writereg),
    .waddr_i   (wb_id_regdest),
    .wdata_i   (wb_id_data)
  );

  logic   illegal, is_beq, is_bne, is_j, is_jr, is_sll;
  logic   wr, mrd, mwr, alusrc, dest_rt;
  aluop_t aluop;

  always_comb begin
    illegal = 1'b0; is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    is_sll  = 1'b0; wr = 1'b0; mrd = 1'b0; mwr = 1'b0; alusrc = 1'b0;
    dest_rt = 1'b0; aluop = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD: wr = 1'b1;
          F_SUB: begin wr = 1'b1; aluop = ALU_SUB; end
          F_AND: begin wr = 1'b1; aluop = ALU_AND; end
          F_OR:  begin wr = 1'b1; aluop = ALU_OR;  end
          F_SLT: begin wr = 1'b1; aluop = ALU_SLT; end
          F_SLL: begin wr = 1'b1; aluop = ALU_SLL; is_sll = 1'b1; end
          F_JR:  is_jr = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin wr = 1'b1; alusrc = 1'b1; dest_rt = 1'b1; end
      OP_LW:   begin wr = 1'b1; mrd = 1'b1; alusrc = 1'b1; dest_rt = 1'b1; end
      OP_SW:   begin mwr = 1'b1; alusrc = 1'b1; end
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_J:    is_j = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  logic taken, redirect;
  assign taken    = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
  assign redirect = reset && !is_id_stall && (taken || is_jr || is_j || illegal);

  always_comb begin
    id_if_selpctype = PC_BRANCH;
    if (redirect) begin
      if (illegal)    id_if_selpctype = PC_EXC;
      else if (is_j)  id_if_selpctype = PC_JUMP;
      else if (is_jr) id_if_selpctype = PC_JR;
    end
  end

  assign id_if_selpcsource = redirect;
  assign id_if_pcimd2ext   = if_id_nextpc + imm_ext;
  assign id_if_rega        = rs_val;
  assign id_if_pcindex     = {if_id_nextpc[31:26], if_id_instruc[25:0]};

  // Stalls load an all-zero bubble; non-writing ops carry regdest 0.
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d = '0;
    if (!is_id_stall) begin
      idex_d.rega      = rs_val;
      idex_d.regb      = rt_val;
      idex_d.imedext   = is_sll ? {27'd0, shamt} : imm_ext;
      idex_d.aluop     = aluop;
      idex_d.selalusrc = alusrc;
      idex_d.regdest   = wr ? (dest_rt ? rt : rd) : 5'd0;
      idex_d.writereg  = wr;
      idex_d.memread   = mrd;
      idex_d.memwrite  = mwr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign id_ex_rega      = idex_q.rega;
  assign id_ex_regb      = idex_q.regb;
  assign id_ex_imedext   = idex_q.imedext;
  assign id_ex_aluop     = idex_q.aluop;
  assign id_ex_selalusrc = idex_q.selalusrc;
  assign id_ex_regdest   = idex_q.regdest;
  assign id_ex_writereg  = idex_q.writereg;
  assign id_ex_memread   = idex_q.memread;
  assign id_ex_memwrite  = idex_q.memwrite;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against an instruction-level reference model,
// plus directed literal expectations.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_id_instruc = '0, if_id_nextpc = '0, wb_id_data = '0;
  logic        is_id_stall = 1'b0, wb_id_writereg = 1'b0;
  logic [4:0]  wb_id_regdest = '0;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext;
  logic [2:0]  id_ex_aluop;
  logic        id_ex_selalusrc, id_ex_writereg, id_ex_memread, id_ex_memwrite;
  logic [4:0]  id_ex_regdest;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc), .is_id_stall(is_id_stall),
    .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
    .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega), .id_if_pcindex(id_if_pcindex),
    .wb_id_writereg(wb_id_writereg), .wb_id_regdest(wb_id_regdest), .wb_id_data(wb_id_data),
    .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
    .id_ex_aluop(id_ex_aluop), .id_ex_selalusrc(id_ex_selalusrc), .id_ex_regdest(id_ex_regdest),
    .id_ex_writereg(id_ex_writereg), .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and expected ID/EX contents.
  localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_OR = 3, M_SLT = 4, M_SLL = 5,
                 M_JR = 6, M_ADDI = 7, M_LW = 8, M_SW = 9, M_BEQ = 10, M_BNE = 11,
                 M_J = 12, M_ILL = 13;

  logic [31:0] m_regs [32];
  logic [31:0] e_rega, e_regb, e_imm;
  logic [2:0]  e_aluop;
  logic [4:0]  e_dest;
  logic        e_src, e_wr, e_mrd, e_mwr;

  function automatic int mnemonic(input logic [31:0] w);
    logic [5:0] fn;
    fn = w[5:0];
    case (w[31:26])
      6'd0: case (fn)
              6'd32: return M_ADD;
              6'd34: return M_SUB;
              6'd36: return M_AND;
              6'd37: return M_OR;
              6'd42: return M_SLT;
              6'd0:  return M_SLL;
              6'd8:  return M_JR;
              default: return M_ILL;
            endcase
      6'd8:  return M_ADDI;
      6'd35: return M_LW;
      6'd43: return M_SW;
      6'd4:  return M_BEQ;
      6'd5:  return M_BNE;
      6'd2:  return M_J;
      default: return M_ILL;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_id_writereg && wb_id_regdest == a) return wb_id_data;
    return m_regs[a];
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      if (!reset) begin
        chk("rst_ex_rega", id_ex_rega, 0);        chk("rst_ex_regb", id_ex_regb, 0);
        chk("rst_ex_imm", id_ex_imedext, 0);      chk("rst_ex_aluop", id_ex_aluop, 0);
        chk("rst_ex_alusrc", id_ex_selalusrc, 0); chk("rst_ex_dest", id_ex_regdest, 0);
        chk("rst_ex_wr", id_ex_writereg, 0);      chk("rst_ex_mrd", id_ex_memread, 0);
        chk("rst_ex_mwr", id_ex_memwrite, 0);     chk("rst_selpcsource", id_if_selpcsource, 0);
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        {e_rega, e_regb, e_imm, e_aluop, e_dest, e_src, e_wr, e_mrd, e_mwr} = '0;
      end else begin
        int m;
        logic [31:0] a, b, imm;
        logic        redir;
        logic [1:0]  ptype;
        chk("ex_rega", id_ex_rega, e_rega);       chk("ex_regb", id_ex_regb, e_regb);
        chk("ex_imm", id_ex_imedext, e_imm);      chk("ex_aluop", id_ex_aluop, e_aluop);
        chk("ex_alusrc", id_ex_selalusrc, e_src); chk("ex_dest", id_ex_regdest, e_dest);
        chk("ex_wr", id_ex_writereg, e_wr);       chk("ex_mrd", id_ex_memread, e_mrd);
        chk("ex_mwr", id_ex_memwrite, e_mwr);

        m   = mnemonic(if_id_instruc);
        a   = m_read(if_id_instruc[25:21]);
        b   = m_read(if_id_instruc[20:16]);
        imm = {{16{if_id_instruc[15]}}, if_id_instruc[15:0]};
        redir = !is_id_stall && ((m == M_BEQ && a == b) || (m == M_BNE && a != b) ||
                                 m == M_JR || m == M_J || m == M_ILL);
        ptype = !redir ? 2'd0 : (m == M_ILL) ? 2'd3 : (m == M_J) ? 2'd2 : (m == M_JR) ? 2'd1 : 2'd0;
        chk("selpcsource", id_if_selpcsource, redir);
        chk("selpctype", id_if_selpctype, ptype);
        chk("pcimd2ext", id_if_pcimd2ext, if_id_nextpc + imm);
        chk("if_rega", id_if_rega, a);
        chk("pcindex", id_if_pcindex, {if_id_nextpc[31:26], if_id_instruc[25:0]});

        if (is_id_stall) begin
          {e_rega, e_regb, e_imm, e_aluop, e_dest, e_src, e_wr, e_mrd, e_mwr} = '0;
        end else begin
          e_rega  = a;
          e_regb  = b;
          e_imm   = (m == M_SLL) ? {27'd0, if_id_instruc[10:6]} : imm;
          e_aluop = (m == M_SUB) ? 3'd1 : (m == M_AND) ? 3'd2 : (m == M_OR) ? 3'd3 :
                    (m == M_SLT) ? 3'd4 : (m == M_SLL) ? 3'd5 : 3'd0;
          e_src   = (m == M_ADDI || m == M_LW || m == M_SW);
          e_wr    = (m <= M_SLL) || m == M_ADDI || m == M_LW;
          e_mrd   = (m == M_LW);
          e_mwr   = (m == M_SW);
          e_dest  = !e_wr ? 5'd0 : (m <= M_SLL) ? if_id_instruc[15:11] : if_id_instruc[20:16];
        end
        if (wb_id_writereg && wb_id_regdest != 0) m_regs[wb_id_regdest] = wb_id_data;
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] npc, input logic st,
                       input logic we, input logic [4:0] wr, input logic [31:0] dat);
    @(posedge clock);
    #1;
    if_id_instruc = ins; if_id_nextpc = npc; is_id_stall = st;
    wb_id_writereg = we; wb_id_regdest = wr; wb_id_data = dat;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [7];
    logic [5:0] fns [7];
    logic [4:0] rs, rt;
    int k;
    ops = '{6'd8, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd8};
    rs = 5'($urandom_range(0, 7));
    rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 7));
    k  = $urandom_range(0, 13);
    if (k < 7)  return {6'd0, rs, rt, 5'($urandom), 5'($urandom), fns[k]};
    if (k < 13) return {ops[k-7], rs, rt, 16'($urandom)};
    return $urandom;
  endfunction

  initial begin
    chk_en = 1'b1;
    repeat (4) drive($urandom, $urandom, 1'($urandom), 1'b1, 5'($urandom), $urandom);
    drive(32'h0, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;

    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      drive({6'd0, r, r, 5'd0, 5'd0, 6'h20}, 32'h2, 1'b0, 1'b0, 5'd0, 32'h0);
      #2 chk("post_reset_zero", id_if_rega, 32'h0);
    end

    drive(32'h0, 32'h3, 1'b0, 1'b1, 5'd3, 32'd5);
    drive(32'h2064_0007, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(32'h0, 32'h5, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("addi_rega", id_ex_rega, 32'd5);      chk("addi_imm", id_ex_imedext, 32'd7);
    chk("addi_aluop", id_ex_aluop, 3'b000);   chk("addi_alusrc", id_ex_selalusrc, 1'b1);
    chk("addi_dest", id_ex_regdest, 5'd4);    chk("addi_wr", id_ex_writereg, 1'b1);

    drive(32'h1042_FFFE, 32'h10, 1'b0, 1'b1, 5'd2, 32'h1234);
    #2;
    chk("beq_src", id_if_selpcsource, 1'b1);  chk("beq_type", id_if_selpctype, 2'b00);
    chk("beq_target", id_if_pcimd2ext, 32'h0E);

    drive(32'h1400_0005, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0);
    #2 chk("bne_r0_src", id_if_selpcsource, 1'b0);
    drive(32'h0800_0003, 32'h20, 1'b0, 1'b1, 5'd5, 32'h55);
    #2;
    chk("j_src", id_if_selpcsource, 1'b1);    chk("j_type", id_if_selpctype, 2'b10);
    chk("j_index", id_if_pcindex, 32'h3);
    drive(32'h00A0_0008, 32'h21, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("jr_type", id_if_selpctype, 2'b01);   chk("jr_rega", id_if_rega, 32'h55);

    drive(32'hFC00_0000, 32'h22, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("ill_src", id_if_selpcsource, 1'b1);  chk("ill_type", id_if_selpctype, 2'b11);
    drive(32'h0, 32'h41, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("ill_wr", id_ex_writereg, 1'b0);      chk("ill_mrd", id_ex_memread, 1'b0);
    chk("ill_mwr", id_ex_memwrite, 1'b0);

    drive(32'h8C01_0000, 32'h42, 1'b1, 1'b0, 5'd0, 32'h0);
    #2 chk("lw_stall_src", id_if_selpcsource, 1'b0);
    drive(32'h8C01_0000, 32'h42, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("stall_bubble_mrd", id_ex_memread, 1'b0); chk("stall_bubble_wr", id_ex_writereg, 1'b0);
    drive(32'h0, 32'h43, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("lw_mrd", id_ex_memread, 1'b1);       chk("lw_wr", id_ex_writereg, 1'b1);
    chk("lw_dest", id_ex_regdest, 5'd1);

    for (int n = 0; n < 1500; n++)
      drive(rand_instr(), $urandom, ($urandom_range(0, 4) == 0), 1'($urandom),
            5'($urandom_range(0, 7)), $urandom);

    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clock);
    #1 chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
